// File: rtl/pma_pkg.sv
// Shared helpers for the pipelined-math issue stages: a constant clog2
// and a parameter sanity check.
package pma_pkg;

  function automatic int clog2(input int unsigned n);
    int          r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  function automatic bit params_ok(input int unsigned latency, input int unsigned fifo_depth);
    return (latency >= 1) && (fifo_depth >= 1);
  endfunction

endpackage

// File: rtl/add_issue_if.sv
// Operand-in / result-out handshake bundle for add_issue; names are from the stage's view.
interface add_issue_if #(
  parameter int unsigned a_bits = 32,
  parameter int unsigned b_bits = 32,
  parameter int unsigned q_bits = 32
);
  logic              i_valid;
  logic              o_ready;
  logic [a_bits-1:0] i_a;
  logic [b_bits-1:0] i_b;
  logic              o_valid;
  logic              i_ready;
  logic [q_bits-1:0] o_q;

  modport slave  (input  i_valid, i_a, i_b, i_ready, output o_ready, o_valid, o_q);
  modport master (output i_valid, i_a, i_b, i_ready, input  o_ready, o_valid, o_q);
endinterface

// File: rtl/res_fifo.sv
// Synchronous result FIFO; head entry is presented combinationally, no write-to-read bypass.
module res_fifo
  import pma_pkg::*;
#(
  parameter int unsigned width = 32,
  parameter int unsigned depth = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             push,
  input  logic [width-1:0] wdata,
  input  logic             pop,
  output logic [width-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int unsigned PW = (depth > 1) ? clog2(depth) : 1;
  localparam int unsigned CW = clog2(depth + 1);

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < depth; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(depth));

endmodule

// File: rtl/add_issue.sv
// Valid/ready flow-control wrapper around a fixed-latency adder with no stall:
// a valid pipe tracks real slots, a credit counter reserves FIFO space at accept time.
module add_issue
  import pma_pkg::*;
#(
  parameter int unsigned latency    = 3,
  parameter int unsigned a_bits     = 32,
  parameter int unsigned b_bits     = 32,
  parameter int unsigned q_bits     = 32,
  parameter int unsigned fifo_depth = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  add_issue_if.slave        bus,
  output logic [a_bits-1:0] o_add_a,
  output logic [b_bits-1:0] o_add_b,
  input  logic [q_bits-1:0] i_add_q,
  output logic              o_busy
);
  localparam int unsigned UW = clog2(fifo_depth + 1);

  if (!params_ok(latency, fifo_depth)) begin : g_bad_params
    $error("add_issue: latency and fifo_depth must both be >= 1");
  end

  logic [latency-1:0] r_vld;
  logic [UW-1:0]      r_used;
  logic               accept;
  logic               pop;
  logic               push;
  logic               fifo_empty;
  logic               fifo_full;
  logic [q_bits-1:0]  head;

  assign o_add_a = bus.i_a;
  assign o_add_b = bus.i_b;

  // Ready looks only at the registered credit count, so i_ready never reaches o_ready.
  assign bus.o_ready = ~i_rst & (r_used < UW'(fifo_depth));
  assign accept      = bus.i_valid & bus.o_ready;
  assign pop         = bus.o_valid & bus.i_ready;
  assign push        = r_vld[latency-1] & (~fifo_full | pop);

  assign bus.o_valid = ~i_rst & ~fifo_empty;
  assign bus.o_q     = i_rst ? '0 : head;
  assign o_busy      = ~i_rst & (r_used != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld  <= '0;
      r_used <= '0;
    end else begin
      r_vld[0] <= accept;
      for (int unsigned k = 1; k < latency; k++) r_vld[k] <= r_vld[k-1];
      if (accept && !pop)      r_used <= r_used + UW'(1);
      else if (pop && !accept) r_used <= r_used - UW'(1);
    end
  end

  res_fifo #(
    .width (q_bits),
    .depth (fifo_depth)
  ) u_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (push),
    .wdata (i_add_q),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule
